// File: rtl/rv32v_div_arbiter_if.sv
// Bundle of lane request, response and divider-side signals for rv32v_div_arbiter.
interface rv32v_div_arbiter_if #(
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned NUM_BITS  = 32,
   parameter int unsigned ID_W      = $clog2(NUM_LANES)
);
   // lane request side
   logic [NUM_LANES-1:0]          req_valid;
   logic [NUM_LANES-1:0]          req_ready;
   logic [NUM_LANES-1:0]          req_signed;
   logic [NUM_LANES-1:0]          req_rem;
   logic [NUM_LANES*NUM_BITS-1:0] req_a;
   logic [NUM_LANES*NUM_BITS-1:0] req_b;
   logic                          kill;

   // response side
   logic                          resp_valid;
   logic                          resp_ready;
   logic [ID_W-1:0]               resp_id;
   logic [NUM_BITS-1:0]           resp_data;

   // divider side
   logic                          div_start;
   logic                          div_is_signed;
   logic [NUM_BITS-1:0]           div_dividend;
   logic [NUM_BITS-1:0]           div_divisor;
   logic [NUM_BITS-1:0]           div_quotient;
   logic [NUM_BITS-1:0]           div_remainder;
   logic                          div_finished;

   // the arbiter itself
   modport slave (
      input  req_valid, req_signed, req_rem, req_a, req_b, kill,
      input  resp_ready,
      input  div_quotient, div_remainder, div_finished,
      output req_ready,
      output resp_valid, resp_id, resp_data,
      output div_start, div_is_signed, div_dividend, div_divisor
   );

   // lanes, consumer and divider surrounding the arbiter
   modport master (
      output req_valid, req_signed, req_rem, req_a, req_b, kill,
      output resp_ready,
      output div_quotient, div_remainder, div_finished,
      input  req_ready,
      input  resp_valid, resp_id, resp_data,
      input  div_start, div_is_signed, div_dividend, div_divisor
   );
endinterface

// File: rtl/rv32v_div_arbiter.sv
// Round-robin sequencer sharing one iterative divider among vector lanes.
// Handles divide-by-zero and signed overflow locally; one request in flight.
module rv32v_div_arbiter #(
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned NUM_BITS  = 32,
   parameter int unsigned ID_W      = $clog2(NUM_LANES)
) (
   input logic               CLK,
   input logic               nRST,
   rv32v_div_arbiter_if.slave bus
);

   localparam logic [NUM_BITS-1:0] MIN_NEG = {1'b1, {(NUM_BITS-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPECIAL,
      S_ISSUE,
      S_BUSY,
      S_RESP
   } state_e;

   state_e              state_q;
   logic [ID_W-1:0]     rr_ptr_q;
   logic [ID_W-1:0]     id_q;
   logic [NUM_BITS-1:0] a_q;
   logic [NUM_BITS-1:0] b_q;
   logic                signed_q;
   logic                rem_q;
   logic [NUM_BITS-1:0] resp_data_q;
   logic                resp_valid_q;
   logic                div_start_q;

   logic                grant_vld;
   logic [ID_W-1:0]     grant_id;
   logic [NUM_BITS-1:0] sel_a;
   logic [NUM_BITS-1:0] sel_b;
   logic                sel_signed;
   logic                sel_rem;
   logic                is_special;
   logic [ID_W-1:0]     rr_ptr_d;

   // Round-robin search starting at rr_ptr_q, wrapping around the lanes
   always_comb begin
      int unsigned idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         idx = 32'(rr_ptr_q) + 32'(k);
         if (idx >= NUM_LANES) idx = idx - NUM_LANES;
         for (int i = 0; i < NUM_LANES; i++) begin
            if (!grant_vld && (32'(i) == idx) && bus.req_valid[i]) begin
               grant_vld = 1'b1;
               grant_id  = ID_W'(i);
            end
         end
      end
   end

   // Select the winning lane's operands and classify the special cases
   always_comb begin
      sel_a      = '0;
      sel_b      = '0;
      sel_signed = 1'b0;
      sel_rem    = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (ID_W'(i) == grant_id) begin
            sel_a      = bus.req_a[i*NUM_BITS +: NUM_BITS];
            sel_b      = bus.req_b[i*NUM_BITS +: NUM_BITS];
            sel_signed = bus.req_signed[i];
            sel_rem    = bus.req_rem[i];
         end
      end
      is_special = (sel_b == '0) ||
                   (sel_signed && (sel_a == MIN_NEG) && (sel_b == '1));
      rr_ptr_d   = (32'(grant_id) == NUM_LANES - 1) ? '0 : grant_id + ID_W'(1);
   end

   // Grant is combinational, only in IDLE and never while kill is asserted
   always_comb begin
      bus.req_ready = '0;
      if ((state_q == S_IDLE) && !bus.kill && grant_vld) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (ID_W'(i) == grant_id) bus.req_ready[i] = 1'b1;
         end
      end
   end

   // Sequencer: capture, bypass or launch, wait for completion, hold response
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         id_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         signed_q     <= 1'b0;
         rem_q        <= 1'b0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
         div_start_q  <= 1'b0;
      end else if (bus.kill) begin
         state_q      <= S_IDLE;
         resp_valid_q <= 1'b0;
         div_start_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_vld) begin
                  id_q     <= grant_id;
                  a_q      <= sel_a;
                  b_q      <= sel_b;
                  signed_q <= sel_signed;
                  rem_q    <= sel_rem;
                  rr_ptr_q <= rr_ptr_d;
                  if (is_special) begin
                     state_q <= S_SPECIAL;
                  end else begin
                     state_q     <= S_ISSUE;
                     div_start_q <= 1'b1;
                  end
               end
            end
            S_SPECIAL: begin
               if (b_q == '0) resp_data_q <= rem_q ? a_q : '1;
               else           resp_data_q <= rem_q ? '0  : a_q;
               resp_valid_q <= 1'b1;
               state_q      <= S_RESP;
            end
            S_ISSUE: begin
               div_start_q <= 1'b0;
               state_q     <= S_BUSY;
            end
            S_BUSY: begin
               if (bus.div_finished) begin
                  resp_data_q  <= rem_q ? bus.div_remainder : bus.div_quotient;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_id       = id_q;
   assign bus.resp_data     = resp_data_q;
   assign bus.div_start     = div_start_q;
   assign bus.div_is_signed = signed_q;
   assign bus.div_dividend  = a_q;
   assign bus.div_divisor   = b_q;

endmodule

// File: tb/tb_rv32v_div_arbiter.sv
// Bench for rv32v_div_arbiter: directed and random requests against a reference model.
module tb_rv32v_div_arbiter;

   localparam int unsigned NL = 2;
   localparam int unsigned NB = 32;
   localparam logic [31:0] MINV = 32'h8000_0000;
   localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

   logic CLK;
   logic nRST;

   rv32v_div_arbiter_if #(.NUM_LANES(NL), .NUM_BITS(NB)) bus ();

   rv32v_div_arbiter #(.NUM_LANES(NL), .NUM_BITS(NB)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;
   int rr_m     = 0;
   logic [NL-1:0] pend;
   logic [31:0]   la [NL];
   logic [31:0]   lb [NL];
   logic          ls [NL];
   logic          lr [NL];
   logic [31:0]   last_data;
   int            spur_req = 0;

   // RISC-V DIV/DIVU/REM/REMU result
   function automatic logic [31:0] rv_ref(logic [31:0] a, logic [31:0] b, logic s, logic r);
      if (b == 32'd0) return r ? a : ALL1;
      if (s && a == MINV && b == ALL1) return r ? 32'd0 : a;
      if (s) return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return r ? a % b : a / b;
   endfunction

   // Divider stand-in: 17-cycle latency, garbage on its outputs except at completion
   int          dcnt     = 0;
   int          spur_done = 0;
   logic [31:0] eq, er;
   always @(negedge CLK) begin
      if (!nRST) begin
         dcnt = 0;
         bus.div_finished = 1'b0;
      end else begin
         bus.div_finished  = 1'b0;
         bus.div_quotient  = $urandom;
         bus.div_remainder = $urandom;
         if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
               bus.div_finished  = 1'b1;
               bus.div_quotient  = eq;
               bus.div_remainder = er;
            end
         end else if (spur_req > spur_done) begin
            spur_done++;
            bus.div_finished = 1'b1;
         end
         if (bus.div_start === 1'b1) begin
            dcnt = 17;
            if (bus.div_divisor == 32'd0 ||
                (bus.div_is_signed && bus.div_dividend == MINV && bus.div_divisor == ALL1)) begin
               eq = 32'hDEAD_BEEF;
               er = 32'hDEAD_BEEF;
            end else if (bus.div_is_signed) begin
               eq = 32'($signed(bus.div_dividend) / $signed(bus.div_divisor));
               er = 32'($signed(bus.div_dividend) % $signed(bus.div_divisor));
            end else begin
               eq = bus.div_dividend / bus.div_divisor;
               er = bus.div_dividend % bus.div_divisor;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic set_req(input int lane, input logic s, input logic r,
                          input logic [31:0] a, input logic [31:0] b);
      la[lane] = a; lb[lane] = b; ls[lane] = s; lr[lane] = r;
      bus.req_signed[lane]        = s;
      bus.req_rem[lane]           = r;
      bus.req_a[lane*NB +: NB]    = a;
      bus.req_b[lane*NB +: NB]    = b;
      bus.req_valid[lane]         = 1'b1;
      pend[lane]                  = 1'b1;
   endtask

   task automatic rand_req(input int lane);
      logic [31:0] a, b;
      int sel;
      sel = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = MINV; b = ALL1; end
      else if (sel == 2) begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
      set_req(lane, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b);
   endtask

   // Oldest-pointer-first pick among pending lanes
   function automatic int exp_lane();
      for (int k = 0; k < NL; k++) begin
         if (pend[(rr_m + k) % NL]) return (rr_m + k) % NL;
      end
      return 0;
   endfunction

   task automatic wait_grant(output int lane);
      int cyc;
      #1;
      lane = exp_lane();
      cyc  = 0;
      while (bus.req_ready == '0 && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("grant_onehot", 32'(bus.req_ready), 32'(1) << lane);
      rr_m = (lane + 1) % NL;
   endtask

   task automatic serve(input int hold, input bit reraise);
      int lane, cyc, starts;
      bit spec, busy_bad, hold_bad;
      logic [31:0] a, b, expd;
      logic s, r;
      wait_grant(lane);
      a = la[lane]; b = lb[lane]; s = ls[lane]; r = lr[lane];
      spec = (b == 32'd0) || (s && a == MINV && b == ALL1);
      expd = rv_ref(a, b, s, r);
      tick();
      bus.req_valid[lane] = 1'b0;
      pend[lane] = 1'b0;
      #1;
      cyc = 1; starts = 0; busy_bad = 0;
      while (bus.resp_valid !== 1'b1 && cyc < 60) begin
         if (bus.div_start === 1'b1) starts++;
         if (bus.req_ready !== '0) busy_bad = 1;
         tick();
         cyc++;
      end
      chk("resp_latency", 32'(cyc), spec ? 32'd2 : 32'd19);
      chk("div_start_count", 32'(starts), spec ? 32'd0 : 32'd1);
      chk("no_grant_busy", 32'(busy_bad), 32'd0);
      chk("operands_held", {bus.div_dividend ^ a} | {bus.div_divisor ^ b}, 32'd0);
      chk("signed_held", 32'(bus.div_is_signed), 32'(s));
      chk("resp_id", 32'(bus.resp_id), 32'(lane));
      chk("resp_data", bus.resp_data, expd);
      last_data = bus.resp_data;
      hold_bad = 0;
      for (int h = 0; h < hold; h++) begin
         tick();
         if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'(lane) ||
             bus.resp_data !== expd || bus.req_ready !== '0) hold_bad = 1;
      end
      if (hold > 0) chk("resp_hold_stable", 32'(hold_bad), 32'd0);
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      chk("resp_drop", 32'(bus.resp_valid), 32'd0);
      if (reraise) rand_req(lane);
   endtask

   initial begin
      int lane;
      bit bad;
      nRST = 1'b0;
      pend = '0;
      bus.req_valid = '0; bus.req_signed = '0; bus.req_rem = '0;
      bus.req_a = '0; bus.req_b = '0; bus.kill = 1'b0; bus.resp_ready = 1'b0;
      bus.div_quotient = '0; bus.div_remainder = '0; bus.div_finished = 1'b0;
      tick();
      tick();
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
      chk("rst_resp_data", bus.resp_data, 32'd0);
      chk("rst_div_start", 32'(bus.div_start), 32'd0);
      chk("rst_div_ops", bus.div_dividend | bus.div_divisor | 32'(bus.div_is_signed), 32'd0);

      // Both lanes requesting straight out of reset: strict alternation
      set_req(0, 1'b0, 1'b0, 32'd100, 32'd7);
      set_req(1, 1'b0, 1'b1, 32'd100, 32'd7);
      nRST = 1'b1;
      for (int t = 0; t < 4; t++) serve(0, 1'b1);
      bus.req_valid = '0;
      pend = '0;
      tick();

      // Stray divider pulses while idle must not produce a response
      spur_req += 3;
      bad = 0;
      for (int t = 0; t < 8; t++) begin
         tick();
         if (bus.resp_valid !== 1'b0) bad = 1;
      end
      chk("spurious_finish_ignored", 32'(bad), 32'd0);

      // Directed DIVU / REMU
      set_req(0, 1'b0, 1'b0, 32'd100, 32'd7);
      serve(0, 1'b0);
      chk("divu_100_7", last_data, 32'd14);
      set_req(0, 1'b0, 1'b1, 32'd100, 32'd7);
      serve(5, 1'b0);
      chk("remu_100_7", last_data, 32'd2);

      // Divide by zero bypass on lane 1
      set_req(1, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd0);
      serve(0, 1'b0);
      chk("div_by_zero_q", last_data, 32'hFFFF_FFFF);
      set_req(1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0);
      serve(1, 1'b0);
      chk("div_by_zero_r", last_data, 32'hFFFF_FFF9);

      // Signed overflow bypass versus the same operands unsigned
      set_req(0, 1'b1, 1'b0, MINV, ALL1);
      serve(0, 1'b0);
      chk("ovf_q", last_data, MINV);
      set_req(0, 1'b1, 1'b1, MINV, ALL1);
      serve(0, 1'b0);
      chk("ovf_r", last_data, 32'd0);
      set_req(1, 1'b0, 1'b0, MINV, ALL1);
      serve(2, 1'b0);
      chk("unsigned_ovf_operands_q", last_data, 32'd0);

      // Kill in IDLE suppresses the grant for that cycle
      set_req(1, 1'b0, 1'b0, 32'd55, 32'd5);
      bus.kill = 1'b1;
      #1;
      chk("kill_idle_no_grant", 32'(bus.req_ready), 32'd0);
      tick();
      bus.kill = 1'b0;
      serve(0, 1'b0);
      chk("after_idle_kill", last_data, 32'd11);

      // Kill in the sixth BUSY cycle abandons the divider run
      set_req(0, 1'b0, 1'b0, 32'd999, 32'd3);
      wait_grant(lane);
      tick();
      bus.req_valid[lane] = 1'b0;
      pend[lane] = 1'b0;
      for (int t = 0; t < 6; t++) tick();
      bus.kill = 1'b1;
      tick();
      bus.kill = 1'b0;
      chk("kill_busy_no_resp", 32'(bus.resp_valid), 32'd0);
      bad = 0;
      for (int t = 0; t < 25; t++) begin
         tick();
         if (bus.resp_valid !== 1'b0 || bus.div_start !== 1'b0) bad = 1;
      end
      chk("late_finish_ignored", 32'(bad), 32'd0);
      set_req(1, 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7);
      serve(0, 1'b0);
      chk("after_busy_kill", last_data, 32'hFFFF_FFFE);

      // Reset in the middle of a divider run
      set_req(0, 1'b1, 1'b0, 32'd1234, 32'd9);
      wait_grant(lane);
      tick();
      bus.req_valid = '0;
      pend = '0;
      for (int t = 0; t < 4; t++) tick();
      nRST = 1'b0;
      #1;
      chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("midrst_div_start", 32'(bus.div_start), 32'd0);
      chk("midrst_div_ops", bus.div_dividend | bus.div_divisor | 32'(bus.div_is_signed), 32'd0);
      chk("midrst_resp", bus.resp_data | 32'(bus.resp_id), 32'd0);
      rr_m = 0;
      tick();
      nRST = 1'b1;
      tick();

      // Random traffic with random response back-pressure
      for (int t = 0; t < 8; t++) begin
         int mask;
         mask = $urandom_range(1, 3);
         for (int l = 0; l < NL; l++) if (mask[l]) rand_req(l);
         while (pend != '0) serve($urandom_range(0, 3), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv32v_div_arbiter.md
# rv32v_div_arbiter

Sequencer and round-robin arbiter that shares the single iterative `rv32v_divider` among `NUM_LANES` vector-lane requesters.
- Accepts one element divide/remainder request at a time.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) without using the divider.
- Holds the divider's operands stable, launches it, and returns the selected quotient or remainder on a single response channel tagged with the lane ID.
- Sits between the vector execute lanes and the divider instance.

## Interface
Parameters:
- `NUM_LANES`, 2: number of requesting lanes (≥2).
- `NUM_BITS`, 32: operand width.
- `ID_W`, `$clog2(NUM_LANES)`: lane-ID width.

Ports:
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_LANES  per-lane request valid; held until granted.
- `req_ready`  out  NUM_LANES  one-hot grant; combinational in IDLE only.
- `req_signed`  in  NUM_LANES  1 = DIV/REM, 0 = DIVU/REMU.
- `req_rem`  in  NUM_LANES  1 = return remainder, 0 = return quotient.
- `req_a`  in  NUM_LANES*NUM_BITS  dividends; lane i occupies `[i*NUM_BITS +: NUM_BITS]`.
- `req_b`  in  NUM_LANES*NUM_BITS  divisors; same packing as `req_a`.
- `kill`  in  1  synchronous abort of the operation in flight.
- `resp_valid`  out  1  result valid.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  ID_W  lane that owns the result.
- `resp_data`  out  NUM_BITS  result.
- `div_start`  out  1  one-cycle launch pulse to the divider.
- `div_is_signed`  out  1  divider signed mode.
- `div_dividend`  out  NUM_BITS  divider dividend.
- `div_divisor`  out  NUM_BITS  divider divisor.
- `div_quotient`  in  NUM_BITS  divider quotient.
- `div_remainder`  in  NUM_BITS  divider remainder.
- `div_finished`  in  1  divider completion.

## Operation
States:
- **IDLE**
  - Round-robin arbitration: search starts at `rr_ptr` and wraps; the first lane with `req_valid` set wins.
  - The winning lane sees `req_ready` high for that cycle.
  - At the edge: latch `a`, `b`, `signed`, `rem` and `id` into operand registers, and set `rr_ptr` to `(id+1) mod NUM_LANES`.
  - Next state is SPECIAL if a special case applies, else ISSUE.
- **SPECIAL**
  - Divide-by-zero (`b==0`): quotient = all ones, remainder = `a`.
  - Signed overflow (`signed`, `a==1<<(NUM_BITS-1)`, `b=='1`): quotient = `a`, remainder = 0.
  - Divide-by-zero takes priority over signed overflow.
  - Load the result register and go to RESP.
- **ISSUE**
  - Assert `div_start` for exactly this cycle, then go to BUSY.
- **BUSY**
  - Wait for `div_finished`. The first `div_finished` seen in BUSY is the completion.
  - At that edge, load `resp_data` with `div_remainder` if `rem`, else `div_quotient`, and go to RESP.
- **RESP**
  - `resp_valid` = 1 with `resp_id` and `resp_data` held stable.
  - On `resp_valid && resp_ready`, go to IDLE.
  - No new grant is issued in the same cycle as the response handshake.

Operand outputs:
- `div_dividend`, `div_divisor` and `div_is_signed` come straight from the operand registers.
- They stay constant through ISSUE, BUSY and RESP; the divider needs its inputs stable for the whole operation.

`div_finished` is ignored outside BUSY. This covers:
- the divider's free-running pulse after reset;
- repeated pulses while the divider sits idle with count 0.

`kill`:
- In any state, `kill` forces IDLE at the next edge and clears `resp_valid`.
- `rr_ptr` is kept.
- An in-flight divider run is abandoned; its later `div_finished` is ignored.
- In IDLE, `kill` suppresses the grant that cycle: `req_ready` = 0.

No arithmetic is done in this block beyond the special-case compares.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` = 0, operand and result registers 0;
  - `req_ready` 0 (no requests), `resp_valid` 0, `resp_id` 0, `resp_data` 0, `div_start` 0;
  - `div_is_signed`, `div_dividend`, `div_divisor` 0.
- Normal path, with the grant in cycle 0:
  - `div_start` high in cycle 1;
  - divider asserts `div_finished` 17 cycles after the `div_start` edge, in cycle 18;
  - `resp_valid` from cycle 19.
- The block does not count cycles; it waits on `div_finished`, so a different divider latency needs no change.
- Special path: grant in cycle 0, SPECIAL in cycle 1, `resp_valid` from cycle 2.
- Throughput: at most one request in flight. The next grant comes no earlier than the cycle after the response handshake.
- Simultaneous requests from all lanes are served in order `rr_ptr`, `rr_ptr+1`, … with wrap-around.
- Reset asserted mid-operation returns every output to its reset value immediately.

## Test plan
- Lane 0 DIVU `a=100`, `b=7`, quotient requested → one `div_start` in cycle 1, `resp_valid` from cycle 19, `resp_data=14`, `resp_id=0`; REM variant returns 2.
- Both lanes request continuously from reset → grants alternate 0, 1, 0, 1; each grant follows the previous response handshake by at least 1 cycle.
- Lane 1 DIV `b=0`, `a=0xFFFF_FFF9` → no `div_start`, `resp_valid` in cycle 2, quotient `0xFFFF_FFFF`; REM returns `0xFFFF_FFF9`.
- DIV `a=0x8000_0000`, `b=0xFFFF_FFFF`, signed → bypass: quotient `0x8000_0000`, remainder 0; the same operands unsigned go to the divider and give quotient 0.
- Hold `resp_ready=0` for 5 cycles in RESP → `resp_valid`, `resp_id` and `resp_data` stable; no new `req_ready` until the handshake.
- Assert `kill` in cycle 6 of BUSY → IDLE next cycle, no `resp_valid`, later `div_finished` ignored; the next request completes correctly.
